dht_poll_ctrl: RTL and testbench
================================

# dht_poll_ctrl

Sequencer for the `dht_11` sensor driver. It issues driver start pulses on a fixed poll schedule and enforces the sensor's minimum inter-read gap. It retries failed reads (bad checksum, driver abort, watchdog), latches the last good sample, and raises a sensor fault after repeated failures. It sits between the DHT11 driver and the warning/display logic, and generates hysteretic over-threshold alarms for temperature and humidity.

## Interface
- `POLL_CYCLES`, 80_000_000, clock cycles from one read completing to the next scheduled start (2 s at 40 MHz).
- `MIN_GAP_CYCLES`, 40_000_000, minimum cycles between read completion (or reset) and any start (1 s).
- `READ_TIMEOUT`, 1_600_000, watchdog from start to result (40 ms).
- `MAX_RETRY`, 3, consecutive failures that assert `sensor_fault`; range 1..15.
- `HYST`, 2, alarm release hysteresis in sensor units.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  level; polling runs while high.
- `force_req`  in  1  one-cycle request for an early read.
- `temp_hi_th`  in  8  temperature alarm threshold (°C).
- `hum_hi_th`  in  8  humidity alarm threshold (%RH).
- `drv_start`  out  1  one-cycle start pulse to the driver.
- `drv_busy`  in  1  driver busy.
- `drv_valid`  in  1  driver result strobe.
- `drv_checksum`  in  1  checksum-OK, qualified by `drv_valid`.
- `drv_hum`  in  8  driver humidity.
- `drv_temp`  in  8  driver temperature.
- `temp_out`  out  8  last good temperature.
- `hum_out`  out  8  last good humidity.
- `data_valid`  out  1  sticky; set by the first good read.
- `new_sample`  out  1  one-cycle pulse when `temp_out`/`hum_out` update.
- `sensor_fault`  out  1  set at `MAX_RETRY` consecutive failures; cleared by a good read.
- `fail_cnt`  out  4  consecutive-failure count, saturating at 15.
- `alarm_temp`  out  1  hysteretic temperature alarm.
- `alarm_hum`  out  1  hysteretic humidity alarm.

## Operation
- Reset values: all outputs 0; state IDLE; gap counter 0; force pending flag 0.
- States: IDLE, GAP, KICK, WAIT_BUSY, WAIT_DONE, EVAL.
- IDLE:
  - Go to GAP when `enable`=1.
  - On entry from reset, the gap target is `MIN_GAP_CYCLES`.
- GAP:
  - The counter increments each cycle.
  - Go to KICK when the counter reaches the target.
  - Also go to KICK when force is pending and counter ≥ `MIN_GAP_CYCLES`.
  - If `enable`=0, go to IDLE and keep the counter.
- KICK: drive `drv_start`=1 for exactly one cycle, clear force pending, go to WAIT_BUSY.
- WAIT_BUSY:
  - Go to WAIT_DONE when `drv_busy`=1.
  - If busy has not risen within 4 cycles, the read is a failure.
- WAIT_DONE:
  - `drv_valid`=1 captures `drv_checksum`/`drv_hum`/`drv_temp`; go to EVAL.
  - `drv_busy`=0 without `drv_valid` is a failure.
  - `drv_valid` and `drv_busy`=0 in the same cycle: valid wins.
  - Watchdog reaching `READ_TIMEOUT` is a failure.
- EVAL, checksum OK:
  - Update `temp_out`/`hum_out`; pulse `new_sample`; set `data_valid`.
  - Clear `fail_cnt` and `sensor_fault`.
  - Gap target = `POLL_CYCLES`.
- EVAL, failure:
  - Increment `fail_cnt` (saturating); `sensor_fault` ← (`fail_cnt`+1 ≥ `MAX_RETRY`).
  - Held outputs are unchanged.
  - Gap target = `MIN_GAP_CYCLES`, so retries are rate-limited.
- EVAL always clears the gap counter, then goes to GAP (or to IDLE if `enable`=0).
- `enable` deasserted during KICK/WAIT_*: the read completes and is evaluated normally; the block then goes to IDLE.
- `force_req`:
  - Sets the pending flag in any state.
  - Ignored while `enable`=0.
  - Multiple requests before KICK merge into one.
- Alarms:
  - `alarm_x` sets when `data_valid` and value ≥ threshold.
  - Clears when value < threshold − `HYST`, saturating the subtraction at 0.
  - Evaluated every cycle against the held value and the current threshold.
  - Forced 0 while `data_valid`=0.

## Timing
- `drv_start` is asserted in the cycle after GAP reaches its target.
- `new_sample` and output update occur one cycle after `drv_valid` is sampled.
- `fail_cnt`/`sensor_fault` update in the same EVAL cycle.
- Alarms are registered: one cycle after a value or threshold change.
- The gap counter is at least 27 bits wide. Compare with ≥ so parameter changes cannot cause a wrap.
- A watchdog failure does not pulse the driver again until the gap elapses. The driver returns to IDLE by its own timeouts, which are shorter than `READ_TIMEOUT`.

## Structure
- Package `dht_ctrl_pkg`: state enum, default cycle constants for 40 MHz, `FAIL_CNT_W`=4.
- Sub-module `alarm_hyst` (value, threshold, hyst, enable → registered alarm), instantiated twice.

## Test plan
Scaled parameters (POLL=100, MIN_GAP=40, TIMEOUT=60, MAX_RETRY=3) with a behavioural driver model.
- Reset, `enable`=1, model returns hum=55, temp=30, checksum OK:
  - First `drv_start` comes 40 cycles after enable.
  - `new_sample` follows, with outputs 55/30 and `data_valid`=1.
  - Next start comes 100 cycles after EVAL.
- Model returns checksum bad 3×:
  - Starts are spaced 40 cycles after each EVAL.
  - `fail_cnt` steps 1,2,3; `sensor_fault`=1 at the third failure; outputs hold 55/30.
  - A following good read clears `fail_cnt` and `sensor_fault`.
- Model never returns valid, busy stuck high: watchdog failure after 60 cycles; `fail_cnt`=1.
- Model drops busy without valid: immediate failure; a retry start comes 40 cycles later.
- `force_req` 10 cycles into a 100-cycle gap:
  - Start fires at counter=40, not 100.
  - Two `force_req` pulses produce only one extra read.
- `temp_hi_th`=30, HYST=2:
  - temp 30 → `alarm_temp`=1; 29 stays 1; 27 clears.
  - `enable`=0 mid-read: the read completes, then no further starts.
  - `rst_n` asserted mid-read: all outputs return to 0.

Source files
------------

// File: rtl/dht_ctrl_pkg.sv
// Shared types and 40 MHz default timing constants for the DHT11 poll sequencer.
package dht_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GAP,
    KICK,
    WAIT_BUSY,
    WAIT_DONE,
    EVAL
  } state_e;

  localparam int unsigned DEF_POLL_CYCLES    = 80_000_000;
  localparam int unsigned DEF_MIN_GAP_CYCLES = 40_000_000;
  localparam int unsigned DEF_READ_TIMEOUT   = 1_600_000;
  localparam int unsigned FAIL_CNT_W         = 4;
  localparam int unsigned GAP_CNT_W          = 27;
  // Cycles the driver gets to acknowledge a start by raising busy.
  localparam int unsigned BUSY_WAIT_CYCLES   = 4;

endpackage

// File: rtl/dht_poll_ctrl_alarm_hyst.sv
// Registered over-threshold alarm with a release band of hyst_i units below
// the threshold; held low while the monitored value is not yet valid.
module alarm_hyst
  import dht_ctrl_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic [W-1:0] value_i,
  input  logic [W-1:0] thresh_i,
  input  logic [W-1:0] hyst_i,
  output logic         alarm_o
);

  logic         alarm_q, alarm_d;
  logic [W-1:0] release_lvl;

  always_comb begin
    release_lvl = (thresh_i > hyst_i) ? (thresh_i - hyst_i) : '0;
    alarm_d     = alarm_q;
    if (!en_i) begin
      alarm_d = 1'b0;
    end else if (value_i >= thresh_i) begin
      alarm_d = 1'b1;
    end else if (value_i < release_lvl) begin
      alarm_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alarm_q <= 1'b0;
    else        alarm_q <= alarm_d;
  end

  assign alarm_o = alarm_q;

endmodule

// File: rtl/dht_poll_ctrl.sv
// Poll sequencer for the dht_11 driver: schedules reads, retries failures with
// a rate limit, holds the last good sample and raises hysteretic alarms.
module dht_poll_ctrl
  import dht_ctrl_pkg::*;
#(
  parameter int unsigned POLL_CYCLES    = DEF_POLL_CYCLES,
  parameter int unsigned MIN_GAP_CYCLES = DEF_MIN_GAP_CYCLES,
  parameter int unsigned READ_TIMEOUT   = DEF_READ_TIMEOUT,
  parameter int unsigned MAX_RETRY      = 3,
  parameter logic [7:0]  HYST           = 8'd2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  force_req,
  input  logic [7:0]            temp_hi_th,
  input  logic [7:0]            hum_hi_th,
  output logic                  drv_start,
  input  logic                  drv_busy,
  input  logic                  drv_valid,
  input  logic                  drv_checksum,
  input  logic [7:0]            drv_hum,
  input  logic [7:0]            drv_temp,
  output logic [7:0]            temp_out,
  output logic [7:0]            hum_out,
  output logic                  data_valid,
  output logic                  new_sample,
  output logic                  sensor_fault,
  output logic [FAIL_CNT_W-1:0] fail_cnt,
  output logic                  alarm_temp,
  output logic                  alarm_hum
);

  localparam int unsigned MAX_GAP = (POLL_CYCLES > MIN_GAP_CYCLES) ? POLL_CYCLES : MIN_GAP_CYCLES;
  localparam int unsigned GAP_REQ_W = $clog2(MAX_GAP + 1);
  localparam int unsigned CNT_W = (GAP_REQ_W > GAP_CNT_W) ? GAP_REQ_W : GAP_CNT_W;
  localparam int unsigned WD_W  = $clog2(READ_TIMEOUT + BUSY_WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] POLL_TGT = CNT_W'(POLL_CYCLES);
  localparam logic [CNT_W-1:0] MIN_TGT  = CNT_W'(MIN_GAP_CYCLES);
  localparam logic [WD_W-1:0]  WD_TGT   = WD_W'(READ_TIMEOUT);
  localparam logic [WD_W-1:0]  BUSY_TGT = WD_W'(BUSY_WAIT_CYCLES);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        gap_cnt_q, gap_cnt_d, gap_next, gap_tgt;
  logic [WD_W-1:0]         wd_q, wd_d, wd_next;
  logic                    long_gap_q, long_gap_d;
  logic                    force_q, force_d;
  logic                    cap_ok_q, cap_ok_d;
  logic [7:0]              cap_hum_q, cap_hum_d, cap_temp_q, cap_temp_d;
  logic [7:0]              temp_q, temp_d, hum_q, hum_d;
  logic                    valid_q, valid_d, new_q, new_d, fault_q, fault_d;
  logic [FAIL_CNT_W-1:0]   fail_q, fail_d;
  logic [FAIL_CNT_W:0]     fail_inc;

  assign gap_next = gap_cnt_q + CNT_W'(1);
  assign gap_tgt  = long_gap_q ? POLL_TGT : MIN_TGT;
  assign wd_next  = wd_q + WD_W'(1);
  assign fail_inc = {1'b0, fail_q} + (FAIL_CNT_W+1)'(1);

  always_comb begin
    state_d    = state_q;
    gap_cnt_d  = gap_cnt_q;
    wd_d       = wd_q;
    long_gap_d = long_gap_q;
    force_d    = force_q | (force_req & enable);
    cap_ok_d   = cap_ok_q;
    cap_hum_d  = cap_hum_q;
    cap_temp_d = cap_temp_q;
    temp_d     = temp_q;
    hum_d      = hum_q;
    valid_d    = valid_q;
    new_d      = 1'b0;
    fault_d    = fault_q;
    fail_d     = fail_q;

    unique case (state_q)
      IDLE: if (enable) state_d = GAP;
      GAP: begin
        if (!enable) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_next;
          if ((gap_next >= gap_tgt) || (force_q && (gap_next >= MIN_TGT))) state_d = KICK;
        end
      end
      KICK: begin
        // A request arriving in the kick cycle itself is kept for a later read.
        force_d = force_req & enable;
        wd_d    = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        wd_d = wd_next;
        if (drv_busy) begin
          state_d = WAIT_DONE;
        end else if (wd_next >= BUSY_TGT) begin
          cap_ok_d = 1'b0;
          state_d  = EVAL;
        end
      end
      WAIT_DONE: begin
        wd_d = wd_next;
        if (drv_valid) begin
          cap_ok_d   = drv_checksum;
          cap_hum_d  = drv_hum;
          cap_temp_d = drv_temp;
          state_d    = EVAL;
        end else if (!drv_busy || (wd_next >= WD_TGT)) begin
          cap_ok_d = 1'b0;
          state_d  = EVAL;
        end
      end
      EVAL: begin
        gap_cnt_d = '0;
        if (cap_ok_q) begin
          temp_d     = cap_temp_q;
          hum_d      = cap_hum_q;
          new_d      = 1'b1;
          valid_d    = 1'b1;
          fail_d     = '0;
          fault_d    = 1'b0;
          long_gap_d = 1'b1;
        end else begin
          fail_d     = (&fail_q) ? fail_q : fail_inc[FAIL_CNT_W-1:0];
          fault_d    = (32'(fail_inc) >= MAX_RETRY);
          long_gap_d = 1'b0;
        end
        state_d = enable ? GAP : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gap_cnt_q  <= '0;
      wd_q       <= '0;
      long_gap_q <= 1'b0;
      force_q    <= 1'b0;
      cap_ok_q   <= 1'b0;
      cap_hum_q  <= '0;
      cap_temp_q <= '0;
      temp_q     <= '0;
      hum_q      <= '0;
      valid_q    <= 1'b0;
      new_q      <= 1'b0;
      fault_q    <= 1'b0;
      fail_q     <= '0;
    end else begin
      state_q    <= state_d;
      gap_cnt_q  <= gap_cnt_d;
      wd_q       <= wd_d;
      long_gap_q <= long_gap_d;
      force_q    <= force_d;
      cap_ok_q   <= cap_ok_d;
      cap_hum_q  <= cap_hum_d;
      cap_temp_q <= cap_temp_d;
      temp_q     <= temp_d;
      hum_q      <= hum_d;
      valid_q    <= valid_d;
      new_q      <= new_d;
      fault_q    <= fault_d;
      fail_q     <= fail_d;
    end
  end

  assign drv_start    = (state_q == KICK);
  assign temp_out     = temp_q;
  assign hum_out      = hum_q;
  assign data_valid   = valid_q;
  assign new_sample   = new_q;
  assign sensor_fault = fault_q;
  assign fail_cnt     = fail_q;

  alarm_hyst #(.W(8)) u_alarm_temp (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (valid_q),
    .value_i  (temp_q),
    .thresh_i (temp_hi_th),
    .hyst_i   (HYST),
    .alarm_o  (alarm_temp)
  );

  alarm_hyst #(.W(8)) u_alarm_hum (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (valid_q),
    .value_i  (hum_q),
    .thresh_i (hum_hi_th),
    .hyst_i   (HYST),
    .alarm_o  (alarm_hum)
  );

endmodule

// File: tb/tb_dht_poll_ctrl.sv
// Directed bench for dht_poll_ctrl with scaled timing and an inline driver model.
module tb_dht_poll_ctrl;

  localparam int M_GOOD = 0;
  localparam int M_BAD  = 1;
  localparam int M_DROP = 2;

  logic       clk = 1'b0;
  logic       rst_n, enable, force_req;
  logic [7:0] temp_hi_th, hum_hi_th;
  logic       drv_start, drv_busy, drv_valid, drv_checksum;
  logic [7:0] drv_hum, drv_temp, temp_out, hum_out;
  logic       data_valid, new_sample, sensor_fault, alarm_temp, alarm_hum;
  logic [3:0] fail_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int n;
  int starts;

  dht_poll_ctrl #(
    .POLL_CYCLES    (100),
    .MIN_GAP_CYCLES (40),
    .READ_TIMEOUT   (60),
    .MAX_RETRY      (3),
    .HYST           (8'd2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .force_req    (force_req),
    .temp_hi_th   (temp_hi_th),
    .hum_hi_th    (hum_hi_th),
    .drv_start    (drv_start),
    .drv_busy     (drv_busy),
    .drv_valid    (drv_valid),
    .drv_checksum (drv_checksum),
    .drv_hum      (drv_hum),
    .drv_temp     (drv_temp),
    .temp_out     (temp_out),
    .hum_out      (hum_out),
    .data_valid   (data_valid),
    .new_sample   (new_sample),
    .sensor_fault (sensor_fault),
    .fail_cnt     (fail_cnt),
    .alarm_temp   (alarm_temp),
    .alarm_hum    (alarm_hum)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("check %-18s observed %0d expected %0d", tag, obs, exp);
  endtask

  // Counts cycles until drv_start is seen; exp < 0 only requires that a start occurs.
  task automatic wait_start(input string tag, input int already, input int exp);
    int k;
    k = already;
    do begin
      tick();
      k++;
    end while (!drv_start && k < 500);
    if (exp < 0) chk(tag, {31'd0, drv_start}, 32'd1);
    else         chk(tag, k, exp);
  endtask

  // Driver model: busy for three cycles, then a result or a silent drop.
  // Returns with the controller in its evaluation cycle.
  task automatic serve(input int mode, input logic [7:0] h, input logic [7:0] t);
    drv_busy = 1'b1;
    repeat (3) tick();
    if (mode == M_DROP) begin
      drv_busy = 1'b0;
    end else begin
      drv_valid    = 1'b1;
      drv_checksum = (mode == M_GOOD);
      drv_hum      = h;
      drv_temp     = t;
    end
    tick();
    drv_valid    = 1'b0;
    drv_busy     = 1'b0;
    drv_checksum = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; force_req = 1'b0;
    temp_hi_th = 8'd200; hum_hi_th = 8'd200;
    drv_busy = 1'b0; drv_valid = 1'b0; drv_checksum = 1'b0;
    drv_hum = 8'd0; drv_temp = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_temp", temp_out, 0);
    chk("rst_hum", hum_out, 0);
    chk("rst_flags", {data_valid, new_sample, sensor_fault, alarm_temp, alarm_hum, drv_start, fail_cnt}, 0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_no_start", {31'd0, drv_start}, 0);

    // First read: enable is registered by the IDLE->GAP edge, gap counts from there.
    enable = 1'b1;
    tick();
    wait_start("first_start", 0, 40);
    serve(M_GOOD, 8'd55, 8'd30);
    chk("ns_in_eval", {31'd0, new_sample}, 0);
    tick();
    chk("ns_pulse", {31'd0, new_sample}, 1);
    chk("hum_55", hum_out, 55);
    chk("temp_30", temp_out, 30);
    chk("data_valid", {31'd0, data_valid}, 1);
    tick();
    chk("ns_one_cycle", {31'd0, new_sample}, 0);
    wait_start("poll_gap", 1, 100);

    // Three checksum failures, each retried after the minimum gap.
    for (int i = 1; i <= 3; i++) begin
      serve(M_BAD, 8'd11, 8'd12);
      tick();
      chk($sformatf("bad_fail_cnt_%0d", i), fail_cnt, i);
      chk($sformatf("bad_fault_%0d", i), {31'd0, sensor_fault}, (i >= 3) ? 1 : 0);
      chk($sformatf("bad_hold_%0d", i), {hum_out, temp_out}, {8'd55, 8'd30});
      wait_start($sformatf("retry_gap_%0d", i), 0, 40);
    end
    serve(M_GOOD, 8'd56, 8'd31);
    tick();
    chk("good_clr_cnt", fail_cnt, 0);
    chk("good_clr_fault", {31'd0, sensor_fault}, 0);
    chk("hum_56", hum_out, 56);
    wait_start("poll_gap2", 0, 100);

    // Busy stuck high, never valid: watchdog failure.
    drv_busy = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (fail_cnt == 4'd0 && n < 100);
    chk("wd_window_60_63", {31'd0, (n >= 60 && n <= 63)}, 1);
    chk("wd_fail_cnt", fail_cnt, 1);
    drv_busy = 1'b0;
    wait_start("wd_retry_gap", 0, 40);

    serve(M_DROP, 8'd0, 8'd0);
    tick();
    chk("drop_fail_cnt", fail_cnt, 2);
    wait_start("drop_retry_gap", 0, 40);
    serve(M_GOOD, 8'd55, 8'd25);
    tick();
    chk("temp_25", temp_out, 25);
    temp_hi_th = 8'd30;
    tick();
    chk("alarm_below_th", {31'd0, alarm_temp}, 0);

    // Two force requests inside a 100-cycle gap: one early start at 40.
    n = 1;
    repeat (9) begin tick(); n++; end
    force_req = 1'b1; tick(); n++; force_req = 1'b0;
    repeat (4) begin tick(); n++; end
    force_req = 1'b1; tick(); n++; force_req = 1'b0;
    wait_start("force_gap", n, 40);
    serve(M_GOOD, 8'd55, 8'd30);
    tick();
    chk("temp_30b", temp_out, 30);
    chk("alarm_lag", {31'd0, alarm_temp}, 0);
    tick();
    chk("alarm_set_30", {31'd0, alarm_temp}, 1);
    wait_start("merged_force", 1, 100);

    serve(M_GOOD, 8'd55, 8'd29);
    tick(); tick();
    chk("alarm_hold_29", {31'd0, alarm_temp}, 1);
    force_req = 1'b1; tick(); force_req = 1'b0;
    wait_start("force_any", 0, -1);
    serve(M_GOOD, 8'd55, 8'd27);
    tick(); tick();
    chk("alarm_clr_27", {31'd0, alarm_temp}, 0);

    // Humidity alarm driven by threshold changes around hum=55.
    hum_hi_th = 8'd55; tick();
    chk("hum_alarm_eq", {31'd0, alarm_hum}, 1);
    hum_hi_th = 8'd57; tick();
    chk("hum_alarm_hold", {31'd0, alarm_hum}, 1);
    hum_hi_th = 8'd58; tick();
    chk("hum_alarm_clr", {31'd0, alarm_hum}, 0);

    // Disable during a read: it completes, then polling stops.
    wait_start("start_b4_dis", 0, -1);
    enable = 1'b0;
    serve(M_GOOD, 8'd40, 8'd20);
    tick();
    chk("dis_ns", {31'd0, new_sample}, 1);
    chk("dis_temp_20", temp_out, 20);
    force_req = 1'b1; tick(); force_req = 1'b0;
    starts = 0;
    repeat (200) begin
      tick();
      if (drv_start) starts++;
    end
    chk("no_start_disabled", starts, 0);
    enable = 1'b1;
    tick();
    wait_start("reenable_gap", 0, 100);

    // Reset in the middle of a read.
    drv_busy = 1'b1;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_temp", temp_out, 0);
    chk("rst_mid_hum", hum_out, 0);
    chk("rst_mid_flags", {data_valid, new_sample, sensor_fault, alarm_temp, alarm_hum, drv_start, fail_cnt}, 0);
    drv_busy = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
